// File: rtl/bp_lce_chan_concentrator.sv
// Concentrates num_lce_p LCE outbound channels onto one network channel (round robin)
// and steers one inbound cmd channel to per-LCE buffered outputs by destination id.
module bp_lce_chan_concentrator #(
    parameter int unsigned num_lce_p      = 2,
    parameter int unsigned msg_width_p    = 128,
    parameter int unsigned cmd_width_p    = 128,
    parameter int unsigned lce_id_width_p = 4,
    parameter int unsigned dst_id_lsb_p   = 0,
    parameter int unsigned fifo_els_p     = 2
) (
    input  logic                               clk_i,
    input  logic                               reset_i,
    input  logic [num_lce_p*msg_width_p-1:0]   in_msg_i,
    input  logic [num_lce_p-1:0]               in_v_i,
    output logic [num_lce_p-1:0]               in_ready_then_o,
    output logic [msg_width_p-1:0]             out_msg_o,
    output logic                               out_v_o,
    input  logic                               out_ready_then_i,
    input  logic [cmd_width_p-1:0]             cmd_i,
    input  logic                               cmd_v_i,
    output logic                               cmd_yumi_o,
    output logic [num_lce_p*cmd_width_p-1:0]   cmd_o,
    output logic [num_lce_p-1:0]               cmd_v_o,
    input  logic [num_lce_p-1:0]               cmd_ready_then_i,
    output logic                               err_o
);

    localparam int unsigned RR_W  = $clog2(num_lce_p);
    localparam int unsigned PTR_W = $clog2(fifo_els_p);
    localparam int unsigned CNT_W = $clog2(fifo_els_p + 1);

    logic [msg_width_p-1:0] omem_q [num_lce_p][fifo_els_p];
    logic [msg_width_p-1:0] omem_d [num_lce_p][fifo_els_p];
    logic [cmd_width_p-1:0] cmem_q [num_lce_p][fifo_els_p];
    logic [cmd_width_p-1:0] cmem_d [num_lce_p][fifo_els_p];

    logic [PTR_W-1:0] ordp_q [num_lce_p], ordp_d [num_lce_p];
    logic [PTR_W-1:0] owrp_q [num_lce_p], owrp_d [num_lce_p];
    logic [CNT_W-1:0] ocnt_q [num_lce_p], ocnt_d [num_lce_p];
    logic [PTR_W-1:0] crdp_q [num_lce_p], crdp_d [num_lce_p];
    logic [PTR_W-1:0] cwrp_q [num_lce_p], cwrp_d [num_lce_p];
    logic [CNT_W-1:0] ccnt_q [num_lce_p], ccnt_d [num_lce_p];

    logic [RR_W-1:0] rr_q, rr_d;
    logic            err_q, err_d;

    logic [RR_W-1:0]           win;
    logic                      any_v;
    logic [lce_id_width_p-1:0] dst;
    logic                      dst_ok;
    logic                      dst_full;

    function automatic logic [PTR_W-1:0] nxt_ptr(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(fifo_els_p - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    // Winner is the first non-empty FIFO scanning upward from the RR pointer with wrap.
    always_comb begin
        int unsigned idx;
        win   = '0;
        any_v = 1'b0;
        for (int unsigned k = 0; k < num_lce_p; k++) begin
            idx = int'(rr_q) + k;
            if (idx >= num_lce_p) idx = idx - num_lce_p;
            if (!any_v && (ocnt_q[idx] != '0)) begin
                any_v = 1'b1;
                win   = RR_W'(idx);
            end
        end
    end

    always_comb begin
        out_v_o   = out_ready_then_i & any_v;
        out_msg_o = omem_q[win][ordp_q[win]];
    end

    // An out-of-range destination never looks full, so it is consumed and dropped.
    always_comb begin
        dst      = cmd_i[dst_id_lsb_p +: lce_id_width_p];
        dst_ok   = 32'(dst) < num_lce_p;
        dst_full = 1'b0;
        for (int unsigned i = 0; i < num_lce_p; i++) begin
            if (32'(dst) == i) dst_full = (ccnt_q[i] == CNT_W'(fifo_els_p));
        end
        cmd_yumi_o = cmd_v_i & !dst_full;
    end

    always_comb begin
        for (int unsigned i = 0; i < num_lce_p; i++) begin
            in_ready_then_o[i]                   = (ocnt_q[i] != CNT_W'(fifo_els_p));
            cmd_v_o[i]                           = cmd_ready_then_i[i] & (ccnt_q[i] != '0);
            cmd_o[i*cmd_width_p +: cmd_width_p]  = cmem_q[i][crdp_q[i]];
        end
        err_o = err_q;
    end

    always_comb begin
        logic enq, deq;
        omem_d = omem_q;
        cmem_d = cmem_q;
        ordp_d = ordp_q;
        owrp_d = owrp_q;
        ocnt_d = ocnt_q;
        crdp_d = crdp_q;
        cwrp_d = cwrp_q;
        ccnt_d = ccnt_q;
        rr_d   = rr_q;
        err_d  = err_q | (cmd_v_i & !dst_ok);
        enq    = 1'b0;
        deq    = 1'b0;

        if (out_v_o) rr_d = (win == RR_W'(num_lce_p - 1)) ? '0 : win + RR_W'(1);

        for (int unsigned i = 0; i < num_lce_p; i++) begin
            enq = in_v_i[i] & in_ready_then_o[i];
            deq = out_v_o & (win == RR_W'(i));
            if (enq) begin
                omem_d[i][owrp_q[i]] = in_msg_i[i*msg_width_p +: msg_width_p];
                owrp_d[i]            = nxt_ptr(owrp_q[i]);
            end
            if (deq) ordp_d[i] = nxt_ptr(ordp_q[i]);
            if (enq && !deq)      ocnt_d[i] = ocnt_q[i] + CNT_W'(1);
            else if (!enq && deq) ocnt_d[i] = ocnt_q[i] - CNT_W'(1);

            enq = cmd_yumi_o & dst_ok & (32'(dst) == i);
            deq = cmd_v_o[i];
            if (enq) begin
                cmem_d[i][cwrp_q[i]] = cmd_i;
                cwrp_d[i]            = nxt_ptr(cwrp_q[i]);
            end
            if (deq) crdp_d[i] = nxt_ptr(crdp_q[i]);
            if (enq && !deq)      ccnt_d[i] = ccnt_q[i] + CNT_W'(1);
            else if (!enq && deq) ccnt_d[i] = ccnt_q[i] - CNT_W'(1);
        end
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            for (int unsigned i = 0; i < num_lce_p; i++) begin
                ordp_q[i] <= '0;
                owrp_q[i] <= '0;
                ocnt_q[i] <= '0;
                crdp_q[i] <= '0;
                cwrp_q[i] <= '0;
                ccnt_q[i] <= '0;
            end
            rr_q  <= '0;
            err_q <= 1'b0;
        end else begin
            ordp_q <= ordp_d;
            owrp_q <= owrp_d;
            ocnt_q <= ocnt_d;
            crdp_q <= crdp_d;
            cwrp_q <= cwrp_d;
            ccnt_q <= ccnt_d;
            rr_q   <= rr_d;
            err_q  <= err_d;
        end
    end

    // Payload storage needs no reset; the cleared counters make stale entries invisible.
    always_ff @(posedge clk_i) begin
        omem_q <= omem_d;
        cmem_q <= cmem_d;
    end

endmodule

// File: tb/tb_bp_lce_chan_concentrator.sv
// Randomized bench for bp_lce_chan_concentrator against a queue-based reference model.
module tb_bp_lce_chan_concentrator;

    localparam int N   = 4;
    localparam int MW  = 16;
    localparam int CW  = 16;
    localparam int IDW = 4;
    localparam int LSB = 4;
    localparam int ELS = 2;

    logic              clk = 1'b0;
    logic              reset_i;
    logic [N*MW-1:0]   in_msg_i;
    logic [N-1:0]      in_v_i;
    logic [N-1:0]      in_ready_then_o;
    logic [MW-1:0]     out_msg_o;
    logic              out_v_o;
    logic              out_ready_then_i;
    logic [CW-1:0]     cmd_i;
    logic              cmd_v_i;
    logic              cmd_yumi_o;
    logic [N*CW-1:0]   cmd_o;
    logic [N-1:0]      cmd_v_o;
    logic [N-1:0]      cmd_ready_then_i;
    logic              err_o;

    always #5 clk = ~clk;

    bp_lce_chan_concentrator #(
        .num_lce_p      (N),
        .msg_width_p    (MW),
        .cmd_width_p    (CW),
        .lce_id_width_p (IDW),
        .dst_id_lsb_p   (LSB),
        .fifo_els_p     (ELS)
    ) dut (
        .clk_i            (clk),
        .reset_i          (reset_i),
        .in_msg_i         (in_msg_i),
        .in_v_i           (in_v_i),
        .in_ready_then_o  (in_ready_then_o),
        .out_msg_o        (out_msg_o),
        .out_v_o          (out_v_o),
        .out_ready_then_i (out_ready_then_i),
        .cmd_i            (cmd_i),
        .cmd_v_i          (cmd_v_i),
        .cmd_yumi_o       (cmd_yumi_o),
        .cmd_o            (cmd_o),
        .cmd_v_o          (cmd_v_o),
        .cmd_ready_then_i (cmd_ready_then_i),
        .err_o            (err_o)
    );

    int errors = 0;
    int checks = 0;

    logic [MW-1:0] oq [N][$];
    logic [CW-1:0] cq [N][$];
    int            rr;
    bit            err_m;
    bit            cmd_pend;
    logic [CW-1:0] cmd_reg;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic clear_model();
        for (int i = 0; i < N; i++) begin
            oq[i].delete();
            cq[i].delete();
        end
        rr       = 0;
        err_m    = 1'b0;
        cmd_pend = 1'b0;
    endtask

    // One cycle: drive at posedge+1, compare at posedge+2, advance model, wait next posedge+1.
    task automatic step(input int pin, input int pout, input int pcmd, input int maxdst);
        logic [N-1:0] exp_rdy, exp_cv;
        int  w, dst;
        bit  any, exp_yumi;
        for (int i = 0; i < N; i++) begin
            exp_rdy[i]          = oq[i].size() < ELS;
            in_v_i[i]           = exp_rdy[i] && ($urandom_range(99) < pin);
            in_msg_i[i*MW +: MW] = MW'($urandom);
        end
        out_ready_then_i = $urandom_range(99) < pout;
        if (!cmd_pend && ($urandom_range(99) < pcmd)) begin
            cmd_pend = 1'b1;
            cmd_reg  = CW'($urandom);
            cmd_reg[LSB +: IDW] = IDW'($urandom_range(maxdst));
        end
        cmd_v_i          = cmd_pend;
        cmd_i            = cmd_reg;
        cmd_ready_then_i = N'($urandom);
        #1;

        check("in_ready", 64'(in_ready_then_o), 64'(exp_rdy));
        any = 1'b0;
        w   = 0;
        for (int k = 0; k < N; k++) begin
            if (!any && oq[(rr + k) % N].size() > 0) begin
                any = 1'b1;
                w   = (rr + k) % N;
            end
        end
        check("out_v", 64'(out_v_o), 64'(out_ready_then_i && any));
        if (out_ready_then_i && any) check("out_msg", 64'(out_msg_o), 64'(oq[w][0]));

        dst = int'(cmd_reg[LSB +: IDW]);
        if (!cmd_pend)     exp_yumi = 1'b0;
        else if (dst >= N) exp_yumi = 1'b1;
        else               exp_yumi = cq[dst].size() < ELS;
        check("cmd_yumi", 64'(cmd_yumi_o), 64'(exp_yumi));
        for (int i = 0; i < N; i++) exp_cv[i] = cmd_ready_then_i[i] && (cq[i].size() > 0);
        check("cmd_v", 64'(cmd_v_o), 64'(exp_cv));
        for (int i = 0; i < N; i++)
            if (exp_cv[i]) check("cmd_o", 64'(cmd_o[i*CW +: CW]), 64'(cq[i][0]));
        check("err", 64'(err_o), 64'(err_m));

        for (int i = 0; i < N; i++) if (exp_cv[i]) void'(cq[i].pop_front());
        if (exp_yumi) begin
            if (dst < N) cq[dst].push_back(cmd_reg);
            else         err_m = 1'b1;
            cmd_pend = 1'b0;
        end
        if (out_ready_then_i && any) begin
            void'(oq[w].pop_front());
            rr = (w + 1) % N;
        end
        for (int i = 0; i < N; i++) if (in_v_i[i]) oq[i].push_back(in_msg_i[i*MW +: MW]);
        @(posedge clk);
        #1;
    endtask

    task automatic reset_mid();
        #3;
        out_ready_then_i = 1'b1;
        cmd_ready_then_i = '1;
        in_v_i           = '0;
        cmd_v_i          = 1'b0;
        reset_i          = 1'b1;
        #1;
        check("rst_out_v", 64'(out_v_o), 64'(0));
        check("rst_cmd_v", 64'(cmd_v_o), 64'(0));
        check("rst_err", 64'(err_o), 64'(0));
        clear_model();
        @(negedge clk);
        reset_i = 1'b0;
        @(posedge clk);
        #1;
        check("rst_in_ready", 64'(in_ready_then_o), 64'({N{1'b1}}));
    endtask

    initial begin
        reset_i          = 1'b1;
        in_msg_i         = '0;
        in_v_i           = '0;
        out_ready_then_i = 1'b1;
        cmd_i            = '0;
        cmd_v_i          = 1'b0;
        cmd_ready_then_i = '1;
        cmd_reg          = '0;
        clear_model();
        #1;
        check("init_out_v", 64'(out_v_o), 64'(0));
        check("init_cmd_v", 64'(cmd_v_o), 64'(0));
        check("init_yumi", 64'(cmd_yumi_o), 64'(0));
        check("init_ready", 64'(in_ready_then_o), 64'({N{1'b1}}));
        check("init_err", 64'(err_o), 64'(0));
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset_i = 1'b0;
        @(posedge clk);
        #1;

        repeat (200) step(60, 70, 50, 3);
        repeat (40)  step(80, 0, 50, 3);
        repeat (30)  step(0, 100, 50, 3);
        repeat (100) step(100, 100, 80, 3);
        repeat (200) step(50, 60, 60, 5);
        repeat (10)  step(90, 0, 80, 3);
        reset_mid();
        repeat (200) step(60, 70, 50, 3);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
